// File: rtl/dmem_responder_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
// One request is outstanding at a time; ready is a single-cycle completion pulse.
interface dmem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  mem_we;
  logic [31:0] dout;
  logic        ready;
  logic        err;

  modport master (
    output req, addr, din, mem_we,
    input  dout, ready, err
  );

  modport slave (
    input  req, addr, din, mem_we,
    output dout, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory responder: latches one request, waits the
// read/write latency, then pulses ready with registered dout/err and commits writes.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 2,
  parameter int WRITE_LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;

  logic [AW-1:0]   idx_p0;
  logic            oor_p0;
  logic [31:0]     din_p0;
  logic [3:0]      we_p0;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   req_idx;
  logic            req_oor;
  logic            req_wr;
  logic [AW-1:0]   cur_idx;
  logic            cur_oor;
  logic            cur_wr;
  logic            unused_addr_lsbs;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lane_en);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign req_idx          = bus.addr[AW+1:2];
  assign req_oor          = |bus.addr[31:AW+2];
  assign req_wr           = |bus.mem_we;
  assign unused_addr_lsbs = ^bus.addr[1:0];

  // A LAT=1 request reaches DONE straight from IDLE, so the outputs must be
  // computed from the live bus rather than the not-yet-latched copy.
  always_comb begin
    cur_idx = idx_p0;
    cur_oor = oor_p0;
    cur_wr  = |we_p0;
    if (state == IDLE) begin
      cur_idx = req_idx;
      cur_oor = req_oor;
      cur_wr  = req_wr;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (req_wr) begin
            cnt_next   = WR_LOAD;
            state_next = (WRITE_LAT == 1) ? DONE : BUSY;
          end else begin
            cnt_next   = RD_LOAD;
            state_next = (READ_LAT == 1) ? DONE : BUSY;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: control state and registered completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.dout  <= 32'h0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bus.ready <= (state_next == DONE);
      bus.err   <= (state_next == DONE) && cur_oor;
      if ((state_next == DONE) && !cur_wr) begin
        bus.dout <= cur_oor ? 32'h0 : mem[cur_idx];
      end
    end
  end

  // Stage p0: request capture (data path, no reset)
  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.req) begin
      idx_p0 <= req_idx;
      oor_p0 <= req_oor;
      din_p0 <= bus.din;
      we_p0  <= bus.mem_we;
    end
  end

  // Stage p1: write commit at the edge that ends DONE
  always_ff @(posedge clk) begin
    if ((state == DONE) && (|we_p0) && !oor_p0) begin
      mem[idx_p0] <= merge_lanes(mem[idx_p0], din_p0, we_p0);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Drives four responders with different read/write latencies from one stimulus
// stream and checks each against a word-array reference model.
module tb_dmem_responder;

  localparam int N = 4;
  localparam int RL [N] = '{2, 1, 3, 5};
  localparam int WL [N] = '{1, 4, 1, 4};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req_v = '0;
  logic [31:0]   addr_s = '0;
  logic [31:0]   din_s = '0;
  logic [3:0]    we_s = '0;
  wire  [N-1:0]  rdy_v;
  wire  [N-1:0]  err_v;
  wire  [31:0]   dout_v [N];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [int];
  logic [31:0] last_dout [N];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder_if bus ();
      assign bus.req    = req_v[g];
      assign bus.addr   = addr_s;
      assign bus.din    = din_s;
      assign bus.mem_we = we_s;
      assign rdy_v[g]   = bus.ready;
      assign err_v[g]   = bus.err;
      assign dout_v[g]  = bus.dout;
      dmem_responder #(
        .DEPTH_WORDS(1024),
        .READ_LAT   (RL[g]),
        .WRITE_LAT  (WL[g])
      ) u_dut (
        .clk  (clk),
        .reset(reset_n),
        .bus  (bus)
      );
    end
  endgenerate

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] we);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = we[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // One transaction on the DUTs selected by mask, optionally scrambling the bus while busy.
  task automatic txn(input logic [N-1:0] mask, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] we, input bit toggle, input string tag);
    int          lat [N];
    logic [31:0] got_d [N];
    logic        got_e [N];
    logic [N-1:0] pend;
    bit          is_oor;
    int          wi;
    logic [31:0] exp_rd;
    is_oor = (a >= 32'h1000);
    wi     = int'(a[11:2]);
    exp_rd = 32'h0;
    if (!is_oor && we == 4'h0) exp_rd = mem_m[wi];
    for (int i = 0; i < N; i++) begin
      lat[i]   = -1;
      got_d[i] = 'x;
      got_e[i] = 1'bx;
    end
    @(negedge clk);
    addr_s = a; din_s = d; we_s = we; req_v = mask;
    pend = mask;
    for (int c = 1; c <= 20 && pend != '0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && rdy_v[i]) begin
          lat[i]   = c;
          got_d[i] = dout_v[i];
          got_e[i] = err_v[i];
          pend[i]  = 1'b0;
          req_v[i] = 1'b0;
        end
      end
      if (toggle) begin
        addr_s = $urandom; din_s = $urandom; we_s = 4'($urandom);
      end
    end
    req_v = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        chk({tag, "_lat"}, i, 32'(lat[i]), 32'((we != 4'h0) ? WL[i] : RL[i]));
        chk({tag, "_err"}, i, 32'(got_e[i]), 32'(is_oor));
        if (we == 4'h0) last_dout[i] = exp_rd;
        chk({tag, "_dout"}, i, got_d[i], last_dout[i]);
        chk({tag, "_pulse"}, i, 32'(rdy_v[i]), 32'h0);
      end
    end
    if (we != 4'h0 && !is_oor) begin
      mem_m[wi] = lane_merge(mem_m.exists(wi) ? mem_m[wi] : 32'h0, d, we);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_at, second_at, pulses, consec;
    logic        prev;
    logic [31:0] d1, d2, a;
    logic [3:0]  we;

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_ready", i, 32'(rdy_v[i]), 32'h0);
      chk("rst_err", i, 32'(err_v[i]), 32'h0);
      chk("rst_dout", i, dout_v[i], 32'h0);
      last_dout[i] = 32'h0;
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Write then read
    txn(4'hF, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr10");
    txn(4'hF, 32'h10, 32'h0, 4'h0, 1'b0, "rd10");
    chk("rd10_const", 0, dout_v[0], 32'hDEADBEEF);

    // Byte lanes
    txn(4'hF, 32'h20, 32'h11223344, 4'hF, 1'b0, "wr20");
    txn(4'hF, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "wr20_lanes");
    txn(4'hF, 32'h20, 32'h0, 4'h0, 1'b0, "rd20");
    chk("lanes_const", 0, dout_v[0], 32'h11BB33DD);

    // Out of range and alias protection
    txn(4'hF, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, "wr0");
    txn(4'hF, 32'h1000, 32'h0, 4'h0, 1'b0, "rd_oor");
    txn(4'hF, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, "wr_oor");
    txn(4'hF, 32'h0, 32'h0, 4'h0, 1'b0, "rd0_alias");
    chk("alias_const", 0, dout_v[0], 32'hCAFEF00D);

    // Back-to-back reads with req held high on dut0
    txn(4'hF, 32'h14, 32'h55AA55AA, 4'hF, 1'b0, "wr14");
    @(negedge clk);
    addr_s = 32'h10; din_s = 32'h0; we_s = 4'h0; req_v = 4'b0001;
    first_at = -1; second_at = -1; pulses = 0; consec = 0; prev = 1'b0;
    d1 = 'x; d2 = 'x;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rdy_v[0]) begin
        pulses++;
        if (prev) consec++;
        if (first_at < 0) begin
          first_at = c; d1 = dout_v[0]; addr_s = 32'h14;
        end else if (second_at < 0) begin
          second_at = c; d2 = dout_v[0]; req_v = '0;
        end
      end
      prev = rdy_v[0];
    end
    req_v = '0;
    chk("b2b_first_at", 0, 32'(first_at), 32'd2);
    chk("b2b_spacing", 0, 32'(second_at - first_at), 32'd3);
    chk("b2b_pulses", 0, 32'(pulses), 32'd2);
    chk("b2b_consec", 0, 32'(consec), 32'd0);
    chk("b2b_d1", 0, d1, mem_m[4]);
    chk("b2b_d2", 0, d2, mem_m[5]);
    last_dout[0] = mem_m[5];

    // Reset during a write's DONE cycle
    txn(4'hF, 32'h30, 32'h0, 4'hF, 1'b0, "wr30_zero");
    txn(4'hF, 32'h10, 32'h0, 4'h0, 1'b0, "rd10_pre_rst");
    @(negedge clk);
    addr_s = 32'h30; din_s = 32'h12345678; we_s = 4'hF; req_v = 4'b0001;
    @(negedge clk);
    chk("rst_done_ready", 0, 32'(rdy_v[0]), 32'h1);
    reset_n = 1'b0;
    req_v = '0;
    #1;
    chk("async_rst_ready", 0, 32'(rdy_v[0]), 32'h0);
    chk("async_rst_err", 0, 32'(err_v[0]), 32'h0);
    chk("async_rst_dout", 0, dout_v[0], 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) last_dout[i] = 32'h0;
    txn(4'hF, 32'h30, 32'h0, 4'h0, 1'b0, "rd30_after_rst");
    chk("rd30_const", 0, dout_v[0], 32'h0);

    // Randomized traffic with the bus scrambled while requests are in flight
    for (int k = 0; k < 16; k++) begin
      txn(4'hF, 32'h100 + 32'(4 * k), $urandom, 4'hF, 1'b0, "rnd_init");
    end
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a < 32'h1000) a[12] = 1'b1;
      end else begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      end
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      txn(4'hF, a, $urandom, we, 1'b1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory interface: the core drives address, write data and byte write enables; this block services them.
- Replaces the single-cycle data memory with a handshaked, multi-cycle responder: request/ready protocol, configurable read and write latency, byte-lane writes and out-of-range error reporting.
- Sits between the core's data port and on-chip word storage in core_top.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; power of two, at least 2.
- READ_LAT, 2, cycles from request acceptance to ready for a read; at least 1.
- WRITE_LAT, 1, cycles from request acceptance to ready for a write; at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  initiator request valid; held high with addr/din/mem_we stable until ready.
- addr  input  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
- din  input  32  write data; byte lane i = din[8i+7:8i].
- mem_we  input  4  byte write enables; 4'b0000 = read, any non-zero value = write of the enabled lanes.
- dout  output  32  read data; valid in the cycle ready=1 for a read, held until the next read completes.
- ready  output  1  one-cycle completion pulse.
- err  output  1  out-of-range flag; valid only when ready=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=0, err=0, dout=32'h0, latency counter=0.
  - An in-flight request is discarded; a pending write is never committed.
  - Storage contents are not cleared.
- Out of range: addr[31:log2(DEPTH_WORDS)+2] != 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req=1 at a rising edge: latch addr, din, mem_we and kind (read/write).
  - Load the counter with LAT-1, where LAT = READ_LAT or WRITE_LAT.
  - Go to DONE if LAT=1, otherwise go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to DONE next cycle.
  - Latched values are used; input changes during BUSY are ignored.
- DONE (one cycle, registered outputs):
  - ready=1; err=1 if the latched address is out of range.
  - Read in range: dout = storage[word index].
  - Read out of range: dout = 32'h0.
  - Write in range: storage lanes with mem_we[i]=1 are updated at the edge ending DONE; other lanes are unchanged.
  - Write out of range: storage is unchanged; dout holds its previous value.
  - Always return to IDLE.
- Latency: a request sampled at edge k gives ready=1 in the cycle after edge k+LAT-1, i.e. LAT cycles after acceptance.
- Minimum spacing is LAT+1 cycles per transaction: req is not sampled in DONE. A req still high in the cycle after ready is treated as a new request.
- Read-after-write: a read accepted after a write's DONE cycle returns the updated data. There is no forwarding case, since there is only one outstanding transaction.
- ready and err are low in IDLE and BUSY.
- Protocol violation (req dropped before ready): the latched transaction still completes normally.
- Reset asserted during BUSY or DONE: immediate return to IDLE with outputs cleared; a write in DONE is not committed.

Test Plan:
- Write then read, READ_LAT=2, WRITE_LAT=1: write addr=0x10, din=0xDEADBEEF, mem_we=4'hF; ready 1 cycle after acceptance. Then read 0x10: ready 2 cycles after acceptance, dout=0xDEADBEEF, err=0.
- Byte lanes: word 0x20 = 0x11223344; write din=0xAABBCCDD, mem_we=4'b0101; read back gives 0x11BB33DD.
- Out-of-range, DEPTH_WORDS=1024: read addr=0x1000 gives ready=1, err=1, dout=0. Write addr=0x1000, din=0xFFFFFFFF, mem_we=4'hF gives err=1. A following read of 0x0 returns its prior value (alias not corrupted).
- Back-to-back requests with req held high: reads of 0x10 and 0x14 complete with ready pulses spaced LAT+1=3 cycles apart; ready is never high for 2 consecutive cycles.
- Reset mid-operation: a write to 0x30 (prior value 0x0) has reset pulled low in its DONE cycle. ready, err and dout go to 0 asynchronously; after release, a read of 0x30 returns 0x0.
- Latency sweep: READ_LAT in {1,3,5} and WRITE_LAT in {1,4}; measured acceptance-to-ready equals the parameter exactly. Inputs toggled during BUSY do not affect the result.
